// File: rtl/branch_cmp_pkg.sv
// Shared types and constants for the branch comparator.
// Contents: cmp_code_t (2-bit condition code), the CMP_* encodings,
// DEFAULT_WIDTH, and cmp_encode(), which maps an {eq, gt} pair to a code.
package branch_cmp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef logic [1:0] cmp_code_t;

    localparam cmp_code_t CMP_EQ  = 2'b00;
    localparam cmp_code_t CMP_LT  = 2'b01;
    localparam cmp_code_t CMP_GT  = 2'b10;
    localparam cmp_code_t CMP_INV = 2'b11;

    // LT is implied when the operands are neither equal nor greater.
    function automatic cmp_code_t cmp_encode(input logic eq, input logic gt);
        if (eq) begin
            return CMP_EQ;
        end
        return gt ? CMP_GT : CMP_LT;
    endfunction

endpackage

// File: rtl/branch_comparator_if.sv
// Operand/result bundle between the register read stage and the branch comparator.
// Signals:
//   w_data_1, w_data_2  operands A and B
//   in_valid            the operand pair is valid this cycle
//   signed_mode         two's-complement compare (present only with BRANCH_CMP_SIGNED_EN)
//   branch              registered condition code
//   out_valid           branch holds a result from a valid pair
// Modports: master drives the operands, slave is the comparator.
interface branch_comparator_if
    import branch_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] w_data_1;
    logic [WIDTH-1:0] w_data_2;
    logic             in_valid;
`ifdef BRANCH_CMP_SIGNED_EN
    logic             signed_mode;
`endif
    cmp_code_t        branch;
    logic             out_valid;

    modport master (
        output w_data_1, w_data_2, in_valid,
`ifdef BRANCH_CMP_SIGNED_EN
        output signed_mode,
`endif
        input  branch, out_valid
    );

    modport slave (
        input  w_data_1, w_data_2, in_valid,
`ifdef BRANCH_CMP_SIGNED_EN
        input  signed_mode,
`endif
        output branch, out_valid
    );

endinterface

// File: rtl/cmp_slice.sv
// Combinational compare cell. It merges the {eq, gt} results of an upper
// and a lower bit range into the {eq, gt} result of the combined range.
// Ports:
//   hi  {eq, gt} of the more significant half
//   lo  {eq, gt} of the less significant half
//   res {eq, gt} of the whole range
module cmp_slice (
    input  logic [1:0] hi,
    input  logic [1:0] lo,
    output logic [1:0] res
);

    // The upper half decides unless it is equal; then the lower half decides.
    assign res[1] = hi[1] & lo[1];
    assign res[0] = hi[0] | (hi[1] & lo[0]);

endmodule

// File: rtl/branch_comparator.sv
// Registered magnitude/equality comparator for the branch unit.
// The result has one cycle of latency.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset; branch goes to CMP_INV and out_valid to 0
//   bus  branch_comparator_if.slave: operands, in_valid, [signed_mode], branch, out_valid
// Optional feature: define BRANCH_CMP_SIGNED_EN to add signed_mode
// (two's-complement compare). Without it, every compare is unsigned.
module branch_comparator
    import branch_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    branch_comparator_if.slave  bus
);

    localparam int unsigned LEVELS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
    localparam int unsigned N      = 1 << LEVELS;

    logic             sign_flip;
    logic [WIDTH-1:0] msb_mask;
    logic [N-1:0]     a_pad;
    logic [N-1:0]     b_pad;
    logic [1:0]       node [1:2*N-1];
    cmp_code_t        code_c;
    cmp_code_t        branch_q;
    logic             out_valid_q;

`ifdef BRANCH_CMP_SIGNED_EN
    assign sign_flip = bus.signed_mode;
`else
    assign sign_flip = 1'b0;
`endif

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign msb_mask = {sign_flip, (WIDTH-1)'(0)};
    // Zero-padding the operands up to a power of two leaves the compare unchanged.
    assign a_pad    = N'(bus.w_data_1 ^ msb_mask);
    assign b_pad    = N'(bus.w_data_2 ^ msb_mask);

    // Heap-ordered tree: leaf N+j holds bit N-1-j, so each left child covers higher bits.
    for (genvar j = 0; j < N; j++) begin : g_leaf
        assign node[N+j] = {~(a_pad[N-1-j] ^ b_pad[N-1-j]),
                            a_pad[N-1-j] & ~b_pad[N-1-j]};
    end

    for (genvar i = 1; i < N; i++) begin : g_node
        cmp_slice u_slice (
            .hi  (node[2*i]),
            .lo  (node[2*i+1]),
            .res (node[i])
        );
    end

    // Unknown operands give the invalid code in simulation. Synthesis never sees this guard.
    always_comb begin
        code_c = cmp_encode(node[1][1], node[1][0]);
`ifndef SYNTHESIS
        if ((^{bus.w_data_1, bus.w_data_2}) === 1'bx) begin
            code_c = CMP_INV;
        end
`endif
    end

    // Result registers. branch holds its value when no valid pair arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_q    <= CMP_INV;
            out_valid_q <= 1'b0;
        end else if (bus.in_valid) begin
            branch_q    <= code_c;
            out_valid_q <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.branch    = branch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_branch_comparator.sv
// Scoreboard bench for branch_comparator. The stimulus process pushes the
// expected response for each cycle. A separate monitor pops and compares.
module tb_branch_comparator;
    import branch_cmp_pkg::*;

    localparam int unsigned W = 16;
`ifdef BRANCH_CMP_SIGNED_EN
    localparam bit HAS_SIGNED = 1'b1;
`else
    localparam bit HAS_SIGNED = 1'b0;
`endif

    typedef struct {
        string     name;
        logic      valid;
        cmp_code_t code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_comparator_if #(.WIDTH(W)) bus ();

    branch_comparator #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t      exp_q[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    cmp_code_t last_code = CMP_INV;

    // Reference: the condition code from the pair's numeric relation.
    function automatic cmp_code_t ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit sm);
        if ($isunknown(a) || $isunknown(b)) begin
            return CMP_INV;
        end
        if (a == b) begin
            return CMP_EQ;
        end
        if (sm) begin
            return ($signed(a) < $signed(b)) ? CMP_LT : CMP_GT;
        end
        return (a < b) ? CMP_LT : CMP_GT;
    endfunction

    // Drive one cycle and record what the outputs must show after the next edge.
    task automatic drive(input string name, input bit r, input bit v,
                         input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.w_data_1 = a;
        bus.w_data_2 = b;
`ifdef BRANCH_CMP_SIGNED_EN
        bus.signed_mode = sm;
`endif
        if (r) begin
            last_code = CMP_INV;
        end else if (v) begin
            last_code = ref_cmp(a, b, sm && HAS_SIGNED);
        end
        e.name  = name;
        e.valid = !r && v;
        e.code  = last_code;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each cycle's registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (bus.out_valid !== e.valid || bus.branch !== e.code) begin
                    n_bad++;
                    $display("FAIL %s: got out_valid=%b branch=%b, expected out_valid=%b branch=%b",
                             e.name, bus.out_valid, bus.branch, e.valid, e.code);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ax;
        logic [W-1:0] bx;
        int           waited;
        int unsigned  kind;
        bit           v;
        bit           sm;

        bus.in_valid = 1'b0;
        bus.w_data_1 = '0;
        bus.w_data_2 = '0;
`ifdef BRANCH_CMP_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif

        drive("reset_0",       1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive("reset_1",       1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0);
        drive("reset_release", 1'b0, 1'b0, 16'h0003, 16'h0004, 1'b0);
        drive("lt",            1'b0, 1'b1, 16'h0005, 16'h0020, 1'b0);
        drive("gt_b2b",        1'b0, 1'b1, 16'h000A, 16'h0006, 1'b0);
        drive("eq_b2b",        1'b0, 1'b1, 16'h0001, 16'h0001, 1'b0);
        drive("hold_load",     1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0);
        drive("hold_idle",     1'b0, 1'b0, 16'h0009, 16'h0001, 1'b0);
        ax = 'z;
        bx = 'x;
        drive("unknown",       1'b0, 1'b1, ax, bx, 1'b0);
        drive("zero_eq",       1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
        drive("ones_eq",       1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        drive("zero_vs_max",   1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
        drive("msb_only",      1'b0, 1'b1, 16'h8000, 16'h0000, 1'b0);
        drive("ffff_1_uns",    1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
        drive("ffff_1_sgn",    1'b0, 1'b1, 16'hFFFF, 16'h0001, HAS_SIGNED);
        drive("8000_7fff_uns", 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0);
        drive("8000_7fff_sgn", 1'b0, 1'b1, 16'h8000, 16'h7FFF, HAS_SIGNED);
        drive("reset_mid",     1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive("after_reset",   1'b0, 1'b0, 16'h1234, 16'h0001, 1'b0);

        // Random pairs, biased toward equal, MSB-only and extreme values.
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 4);
            a    = W'($urandom);
            b    = W'($urandom);
            case (kind)
                1: b = a;
                2: b = a ^ 16'h8000;
                3: begin
                    a = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000;
                    b = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
                end
                default: ;
            endcase
            v  = ($urandom_range(0, 3) != 0);
            sm = HAS_SIGNED && ($urandom_range(0, 1) != 0);
            drive("random", ($urandom_range(0, 63) == 0), v, a, b, sm);
        end

        @(negedge clk);
        bus.in_valid = 1'b0;
        rst          = 1'b0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_comparator.md
Name: branch_comparator

Overview:
Registered magnitude/equality comparator for the f18 MIPS datapath branch unit. It compares two register-file read operands and produces a 2-bit branch condition code. The code is consumed by branch-decision logic in the next pipeline stage. Output is registered, giving one cycle of latency.

Parameters:
WIDTH, 16, operand width in bits (must be >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
w_data_1  input  WIDTH  operand A (register read port 1)
w_data_2  input  WIDTH  operand B (register read port 2)
in_valid  input  1  operands valid this cycle; result register updates only when high
branch  output  2  condition code: 2'b00 A==B, 2'b01 A<B, 2'b10 A>B, 2'b11 reserved/invalid
out_valid  output  1  branch holds a result produced from a valid operand pair

Behaviour:
- Reset: on a rising clk edge with rst=1, branch<=2'b11 and out_valid<=0. rst has priority over in_valid.
- Comparison is unsigned by default. Signed comparison is available only through the optional feature.
- Latency is 1 cycle. If in_valid=1 at edge N, branch and out_valid=1 reflect that operand pair from edge N onward.
- If in_valid=0 at an edge, branch holds its previous value and out_valid<=0.
- Encoding is exclusive; exactly one of EQ, LT or GT applies to a valid pair.
  - 2'b11 is produced only by reset, or in simulation when any operand bit is X/Z.
  - The X/Z check is a case-equality guard inside synthesis_off pragmas. Synthesized logic never emits 2'b11 after the first valid pair.
- Boundaries:
  - A=B=0 and A=B=all-ones give 2'b00.
  - A=0, B=max gives 2'b01.
  - MSB-only difference is decided by the MSB.
- No internal state beyond the two output registers. Back-to-back valid pairs are accepted every cycle.

Optional Feature:
Macro BRANCH_CMP_SIGNED_EN.
- Defined: adds input port signed_mode (1 bit).
  - signed_mode=1 compares operands as two's complement. Example: 16'hFFFF < 16'h0001 gives 2'b01.
  - signed_mode=0 compares unsigned. signed_mode is sampled with the operands when in_valid=1.
- Undefined: no signed_mode port; comparison is always unsigned, so 16'hFFFF vs 16'h0001 gives 2'b10.

Decomposition:
- Package branch_cmp_pkg holds:
  - the 2-bit condition typedef;
  - the constants CMP_EQ=2'b00, CMP_LT=2'b01, CMP_GT=2'b10, CMP_INV=2'b11;
  - the default WIDTH.
- One sub-module, cmp_slice: a combinational 2-bit-result compare cell, reused in a log-depth tree.
  - It merges {eq, gt} pairs from the MSB half and LSB half.
  - The top level instantiates the tree, applies the sign-bit inversion (feature enabled), and registers the result.

Test Plan:
- Reset: rst=1 for 2 cycles -> branch=2'b11, out_valid=0. Release rst with in_valid=0 -> values unchanged.
- Less-than: A=16'h0005, B=16'h0020, in_valid=1 -> next cycle branch=2'b01, out_valid=1.
- Greater-than then equal, back-to-back:
  - Cycle 1: A=16'h000A, B=16'h0006 -> branch=2'b10.
  - Cycle 2: A=16'h0001, B=16'h0001 -> branch=2'b00 on consecutive cycles.
- Hold: valid pair A=3, B=3 (branch=2'b00), then in_valid=0 with A=9, B=1 -> branch stays 2'b00, out_valid=0.
- Unknown inputs (simulation): A=16'hzzzz, B=16'hxxxx, in_valid=1 -> branch=2'b11.
- Sign handling:
  - A=16'hFFFF, B=16'h0001 -> 2'b10 unsigned.
  - With BRANCH_CMP_SIGNED_EN and signed_mode=1 -> 2'b01.
  - Also check A=16'h8000, B=16'h7FFF in both modes.
